mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single 128-bit line memory between the I-cache and D-cache memory ports.
//   Sits between the two cache instances and the memory model.
//   Grants one cache at a time and registers the granted command (op/addr/wdata).
//   Routes mem_ready and mem_rdata back to the granted cache.
// PARAMETERS
//   ADDR_W  28   line address width (word addr [29:2])
//   DATA_W  128  line width
// PORTS
//   clk              in   1       system clock, rising edge
//   rst_n            in   1       asynchronous, active-low reset
//   icache_mem_read  in   1       I-cache line read request
//   icache_mem_write in   1       I-cache line write request
//   icache_mem_addr  in   ADDR_W  I-cache line address
//   icache_mem_wdata in   DATA_W  I-cache write line
//   icache_mem_rdata out  DATA_W  read line to I-cache
//   icache_mem_ready out  1       I-cache transaction done (1-cycle pulse)
//   dcache_mem_*     same set as icache_mem_*, for the D-cache
//   mem_read         out  1       read command to memory
//   mem_write        out  1       write command to memory
//   mem_addr         out  ADDR_W  registered line address
//   mem_wdata        out  DATA_W  registered write line
//   mem_rdata        in   DATA_W  memory read line
//   mem_ready        in   1       memory done (1-cycle pulse per transaction)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - mem_read/mem_write/mem_addr/mem_wdata = 0; both *_mem_ready = 0.
//     - state = IDLE; rr_last = I (D-cache wins the first tie).
//   Mid-transaction reset: command is dropped immediately; the cache re-issues its request after reset.
//   FSM states: IDLE, BUSY.
//   IDLE:
//     - A port requests when read|write is high.
//     - If any port requests: latch winner id, op, addr and wdata; go to BUSY.
//     - Op select: write overrides read if a port asserts both.
//   BUSY:
//     - Drive mem_* from the latched registers. Exactly one of mem_read/mem_write is high.
//     - On mem_ready: pulse the winner's *_mem_ready in the same cycle (combinational).
//     - Also on mem_ready: deassert mem_read/mem_write at the next edge; go to IDLE; rr_last = winner.
//   Read data:
//     - mem_rdata is passed combinationally to both *_mem_rdata.
//     - A port may use it only when its ready is high.
//   Latency:
//     - Request at cycle t in IDLE -> mem command visible at t+1.
//     - mem_ready at cycle k -> port ready at k -> IDLE at k+1 -> next command at k+2.
//   Handshake rules:
//     - A requester holds read/write/addr/wdata stable until its ready pulse.
//     - A requester drops the request in the ready cycle.
//     - Requests arriving during BUSY wait; the loser of a tie waits exactly one transaction.
//     - Writeback followed by allocate from one cache = two separate grants. The other port may win in between (round-robin).
//   mem_ready outside BUSY: ignored; no ready pulse is produced.
//   The non-granted port never sees ready=1.
// CONFIGURATION
//   ARB_FIXED_PRIO_EN defined:
//     - D-cache always wins a simultaneous request; rr_last is unused.
//   ARB_FIXED_PRIO_EN undefined (default):
//     - 2-way round-robin: a tie goes to the port not in rr_last.
// STRUCTURE
//   Package mem_arb_pkg:
//     - state encoding (IDLE=1'b0, BUSY=1'b1);
//     - port ids PORT_I=1'b0, PORT_D=1'b1;
//     - ADDR_W/DATA_W defaults.
//   Sub-module rr_arb2:
//     - pure combinational 2-request picker: inputs req[1:0], last, fixed-prio select;
//     - outputs gnt id and any.
//   Top: FSM, command registers, ready/rdata steering.
// TESTING
//   1. Reset mid-BUSY, D write in flight -> mem_write=0 same cycle, state IDLE, no ready pulses.
//   2. I read addr 0x0000010 alone -> mem_read=1, mem_addr=0x0000010 at t+1.
//      mem_ready with rdata=0xDEADBEEF_..._01 -> icache_mem_ready=1 that cycle with that data; dcache_mem_ready=0.
//   3. I read and D write in the same cycle after reset:
//      - round-robin: D granted first, I after D's ready;
//      - with ARB_FIXED_PRIO_EN: D first, and D again if it re-requests.
//   4. Repeated ties over 4 transactions (round-robin):
//      - grant order D,I,D,I;
//      - each port's wait is never more than one transaction.
//   5. D write 0xA5.. to 0x00000F0, then D read 0x0000010:
//      - two grants, mem_wdata=0xA5.. during the write;
//      - mem_addr changes only after IDLE.
//   6. Spurious mem_ready in IDLE -> no ready pulse, no state change.
//      Port asserts read+write -> memory sees write only.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/port encodings and default widths for the line-memory arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one line-memory port; master issues commands, slave returns data and ready
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-request picker; ties go to D when fixed, else to the port not served last
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  port_t      last,
  input  logic       fixed,
  output port_t      gnt,
  output logic       any
);
  assign any = |req;
  assign gnt = (&req) ? ((fixed || last == PORT_I) ? PORT_D : PORT_I)
                      : (req[PORT_D] ? PORT_D : PORT_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line memory between I- and D-cache, registering the granted command.
// Define ARB_FIXED_PRIO_EN for D-cache fixed priority instead of round-robin.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  icache,
  mem_arbiter_if.slave  dcache,
  mem_arbiter_if.master mem
);
`ifdef ARB_FIXED_PRIO_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif
  state_t            state, state_nx;
  port_t             win, rr_last, gnt;
  logic              any, op_wr, done;
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign req  = {dcache.read | dcache.write, icache.read | icache.write};
  assign done = state == BUSY && mem.ready;
  rr_arb2 u_arb (.req(req), .last(rr_last), .fixed(FIXED), .gnt(gnt), .any(any));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (any ? BUSY : IDLE) : (mem.ready ? IDLE : BUSY);
  end
  // Command is captured once at grant so mem_* stay stable for the whole transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win     <= PORT_I;
      rr_last <= PORT_I;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state == IDLE && any) begin
        win     <= gnt;
        op_wr   <= gnt == PORT_D ? dcache.write : icache.write;
        addr_q  <= gnt == PORT_D ? dcache.addr : icache.addr;
        wdata_q <= gnt == PORT_D ? dcache.wdata : icache.wdata;
      end
      if (done) rr_last <= win;
    end
  assign mem.read     = state == BUSY && !op_wr;
  assign mem.write    = state == BUSY && op_wr;
  assign mem.addr     = addr_q;
  assign mem.wdata    = wdata_q;
  assign icache.ready = done && win == PORT_I;
  assign dcache.ready = done && win == PORT_D;
  assign icache.rdata = mem.rdata;
  assign dcache.rdata = mem.rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam logic [127:0] RD = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] W1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] W2 = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
  localparam logic [127:0] A5 = {16{8'hA5}};
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;
  bit   exp_d;
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ic ();
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) dc ();
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) mm ();
  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .icache(ic), .dcache(dc), .mem(mm));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    {ic.read, ic.write, dc.read, dc.write, mm.ready} = '0;
    ic.addr = '0; dc.addr = '0; ic.wdata = '0; dc.wdata = '0; mm.rdata = '0;
    tick(); tick();
    chk("rst_read", mm.read, 0);
    chk("rst_write", mm.write, 0);
    chk("rst_addr", mm.addr, 0);
    chk("rst_wdata", mm.wdata, 0);
    chk("rst_irdy", ic.ready, 0);
    chk("rst_drdy", dc.ready, 0);
    rst_n = 1'b1;
    tick();
    // I read alone
    ic.read = 1'b1; ic.addr = 28'h0000010;
    tick();
    chk("i_rd_read", mm.read, 1);
    chk("i_rd_write", mm.write, 0);
    chk("i_rd_addr", mm.addr, 28'h0000010);
    chk("i_rd_irdy_early", ic.ready, 0);
    mm.rdata = RD; mm.ready = 1'b1;
    #1;
    chk("i_rd_irdy", ic.ready, 1);
    chk("i_rd_rdata", ic.rdata, RD);
    chk("i_rd_drdy", dc.ready, 0);
    ic.read = 1'b0;
    tick();
    mm.ready = 1'b0;
    #1;
    chk("i_rd_idle", mm.read, 0);
    // simultaneous I read / D write: D wins (rr_last = I)
    ic.read = 1'b1; ic.addr = 28'h0000020;
    dc.write = 1'b1; dc.addr = 28'h0000030; dc.wdata = W1;
    tick();
    chk("tie_d_write", mm.write, 1);
    chk("tie_d_addr", mm.addr, 28'h0000030);
    chk("tie_d_wdata", mm.wdata, W1);
    mm.ready = 1'b1;
    #1;
    chk("tie_d_drdy", dc.ready, 1);
    chk("tie_d_irdy", ic.ready, 0);
    dc.write = 1'b0;
    tick();
    mm.ready = 1'b0;
    #1;
    chk("tie_idle", {mm.read, mm.write}, 0);
    tick();
    chk("tie_i_read", mm.read, 1);
    chk("tie_i_addr", mm.addr, 28'h0000020);
    mm.ready = 1'b1;
    #1;
    chk("tie_i_irdy", ic.ready, 1);
    chk("tie_i_drdy", dc.ready, 0);
    ic.read = 1'b0;
    tick();
    mm.ready = 1'b0;
    // repeated ties: D,I,D,I round-robin or D every time under fixed priority
    ic.read = 1'b1; ic.addr = 28'h0000100;
    dc.read = 1'b1; dc.addr = 28'h0000200;
    for (int n = 0; n < 4; n++) begin
      exp_d = FIXED ? 1'b1 : (n % 2 == 0);
      tick();
      chk($sformatf("rr%0d_addr", n), mm.addr, exp_d ? 28'h0000200 : 28'h0000100);
      mm.ready = 1'b1;
      #1;
      chk($sformatf("rr%0d_drdy", n), dc.ready, exp_d);
      chk($sformatf("rr%0d_irdy", n), ic.ready, !exp_d);
      if (exp_d) dc.read = 1'b0; else ic.read = 1'b0;
      tick();
      mm.ready = 1'b0;
      #1;
      chk($sformatf("rr%0d_idle", n), {mm.read, mm.write}, 0);
      if (exp_d) dc.read = 1'b1; else ic.read = 1'b1;
    end
    ic.read = 1'b0; dc.read = 1'b0;
    tick();
    // D writeback then allocate: two grants, address held through IDLE
    dc.write = 1'b1; dc.addr = 28'h00000F0; dc.wdata = A5;
    tick();
    chk("wb_write", mm.write, 1);
    chk("wb_addr", mm.addr, 28'h00000F0);
    chk("wb_wdata", mm.wdata, A5);
    mm.ready = 1'b1;
    #1;
    chk("wb_drdy", dc.ready, 1);
    dc.write = 1'b0;
    tick();
    mm.ready = 1'b0;
    dc.read = 1'b1; dc.addr = 28'h0000010; dc.wdata = '0;
    #1;
    chk("wb_idle_addr", mm.addr, 28'h00000F0);
    chk("wb_idle_cmd", {mm.read, mm.write}, 0);
    tick();
    chk("al_read", mm.read, 1);
    chk("al_addr", mm.addr, 28'h0000010);
    mm.ready = 1'b1;
    #1;
    chk("al_drdy", dc.ready, 1);
    dc.read = 1'b0;
    tick();
    mm.ready = 1'b0;
    // spurious ready in IDLE
    mm.ready = 1'b1;
    #1;
    chk("sp_irdy", ic.ready, 0);
    chk("sp_drdy", dc.ready, 0);
    tick();
    chk("sp_cmd", {mm.read, mm.write}, 0);
    chk("sp_state", dut.state, IDLE);
    mm.ready = 1'b0;
    // read+write together: memory sees write only
    ic.read = 1'b1; ic.write = 1'b1; ic.addr = 28'h0000040; ic.wdata = W2;
    tick();
    chk("rw_write", mm.write, 1);
    chk("rw_read", mm.read, 0);
    chk("rw_wdata", mm.wdata, W2);
    mm.ready = 1'b1;
    #1;
    chk("rw_irdy", ic.ready, 1);
    ic.read = 1'b0; ic.write = 1'b0;
    tick();
    mm.ready = 1'b0;
    // reset while a D write is in flight
    dc.write = 1'b1; dc.addr = 28'h0000050; dc.wdata = W1;
    tick();
    chk("mr_write_pre", mm.write, 1);
    rst_n = 1'b0; mm.ready = 1'b1;
    #1;
    chk("mr_write", mm.write, 0);
    chk("mr_read", mm.read, 0);
    chk("mr_addr", mm.addr, 0);
    chk("mr_drdy", dc.ready, 0);
    chk("mr_irdy", ic.ready, 0);
    chk("mr_state", dut.state, IDLE);
    mm.ready = 1'b0; dc.write = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_after", {mm.read, mm.write}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
